// File: rtl/mc_arb_pkg.sv
// Shared types and default widths for the memory-controller request arbiter.
package mc_arb_pkg;

  localparam int MC_ARB_NUM_REQ       = 4;
  localparam int MC_ARB_DATA_WIDTH    = 16;
  localparam int MC_ARB_ADDR_WIDTH    = 30;
  localparam int MC_ARB_RD_FIFO_DEPTH = 16;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } req_type_e;

  typedef logic [$clog2(MC_ARB_NUM_REQ)-1:0] req_id_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } oreg_state_e;

endpackage

// File: rtl/mc_arb_id_fifo.sv
// Synchronous ID FIFO: records requester IDs in issue order so completions
// can be routed back. Push when full and pop when empty are ignored.
module mc_arb_id_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_id,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once count says they exist.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/mc_request_arbiter.sv
// Round-robin arbiter sharing the memory controller request port among NUM_REQ
// requesters. Write acknowledges are routed back only when MC_ARB_WR_ACK_EN is defined.
module mc_request_arbiter
  import mc_arb_pkg::*;
#(
  parameter int NUM_REQ       = MC_ARB_NUM_REQ,
  parameter int DATA_WIDTH    = MC_ARB_DATA_WIDTH,
  parameter int ADDR_WIDTH    = MC_ARB_ADDR_WIDTH,
  parameter int RD_FIFO_DEPTH = MC_ARB_RD_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_busy,
  input  logic [NUM_REQ-1:0]            req_type,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            rsp_read_done,
  output logic [DATA_WIDTH-1:0]         rsp_data,
`ifdef MC_ARB_WR_ACK_EN
  output logic [NUM_REQ-1:0]            rsp_write_done,
`endif
  output logic                          err_unexpected_rd,
  output logic                          mc_in_valid,
  output logic                          mc_in_request_type,
  output logic [ADDR_WIDTH-1:0]         mc_in_request_address,
  output logic [DATA_WIDTH-1:0]         mc_in_request_data,
  input  logic                          mc_out_busy,
  input  logic                          mc_read_done,
  input  logic [DATA_WIDTH-1:0]         mc_data_out,
  input  logic                          mc_write_done
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_v;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] data_v;
  assign addr_v = req_addr;
  assign data_v = req_data;

  oreg_state_e      state;
  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   grant_id;
  logic             grant_vld;
  logic             oreg_free;
  logic [NUM_REQ-1:0] elig;
  logic             rd_full, rd_empty;
  logic [IDW-1:0]   rd_head;
  logic             wr_ok;
  logic             grant_is_rd;

  assign oreg_free   = (state == EMPTY) || !mc_out_busy;
  assign mc_in_valid = (state == FULL);
  assign grant_is_rd = grant_vld && (req_type[grant_id] == READ);

  // Reads wait on the pre-pop FIFO state: a same-cycle pop does not unmask them.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      elig[i] = req_valid[i] && (req_type[i] ? wr_ok : !rd_full);
  end

  always_comb begin
    logic [IDW:0] cand;
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = '0;
    if (oreg_free) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        cand = {1'b0, last_grant} + (IDW+1)'(k);
        if (cand >= (IDW+1)'(NUM_REQ)) cand = cand - (IDW+1)'(NUM_REQ);
        if (!grant_vld && elig[cand[IDW-1:0]]) begin
          grant_vld = 1'b1;
          grant_id  = cand[IDW-1:0];
        end
      end
    end
  end

  assign req_busy = grant_vld ? ~(NUM_REQ'(1) << grant_id) : '1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                 <= EMPTY;
      last_grant            <= IDW'(NUM_REQ-1);
      mc_in_request_type    <= 1'b0;
      mc_in_request_address <= '0;
      mc_in_request_data    <= '0;
    end else begin
      if (grant_vld) begin
        state                 <= FULL;
        last_grant            <= grant_id;
        mc_in_request_type    <= req_type[grant_id];
        mc_in_request_address <= addr_v[grant_id];
        mc_in_request_data    <= data_v[grant_id];
      end else if (state == FULL && !mc_out_busy) begin
        state <= EMPTY;
      end
    end
  end

  mc_arb_id_fifo #(.DEPTH(RD_FIFO_DEPTH), .W(IDW)) u_rd_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (grant_is_rd),
    .push_id (grant_id),
    .pop     (mc_read_done),
    .full    (rd_full),
    .empty   (rd_empty),
    .head    (rd_head)
  );

  logic wr_unexpected;

`ifdef MC_ARB_WR_ACK_EN
  logic           wr_full, wr_empty;
  logic [IDW-1:0] wr_head;

  assign wr_ok         = !wr_full;
  assign wr_unexpected = mc_write_done && wr_empty;

  mc_arb_id_fifo #(.DEPTH(RD_FIFO_DEPTH), .W(IDW)) u_wr_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (grant_vld && !grant_is_rd),
    .push_id (grant_id),
    .pop     (mc_write_done),
    .full    (wr_full),
    .empty   (wr_empty),
    .head    (wr_head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rsp_write_done <= '0;
    else     rsp_write_done <= (mc_write_done && !wr_empty) ? (NUM_REQ'(1) << wr_head) : '0;
  end
`else
  logic unused_wr_done;
  assign unused_wr_done = mc_write_done;
  assign wr_ok          = 1'b1;
  assign wr_unexpected  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_read_done     <= '0;
      rsp_data          <= '0;
      err_unexpected_rd <= 1'b0;
    end else begin
      rsp_read_done <= '0;
      if (mc_read_done && !rd_empty) begin
        rsp_read_done <= NUM_REQ'(1) << rd_head;
        rsp_data      <= mc_data_out;
      end
      if ((mc_read_done && rd_empty) || wr_unexpected) err_unexpected_rd <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_request_arbiter.sv
// Randomized scoreboard bench for mc_request_arbiter against a queue-based model.
module tb_mc_request_arbiter;
  localparam int N     = 4;
  localparam int DW    = 16;
  localparam int AW    = 30;
  localparam int DEPTH = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_busy, req_type, rsp_read_done;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [DW-1:0]   rsp_data, mc_data_out, mc_in_request_data;
  logic [AW-1:0]   mc_in_request_address;
  logic            err_unexpected_rd, mc_in_valid, mc_in_request_type;
  logic            mc_out_busy, mc_read_done, mc_write_done;
`ifdef MC_ARB_WR_ACK_EN
  logic [N-1:0]    rsp_write_done;
`endif

  always #5 clk = ~clk;

  mc_request_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_busy(req_busy), .req_type(req_type),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_read_done(rsp_read_done), .rsp_data(rsp_data),
`ifdef MC_ARB_WR_ACK_EN
    .rsp_write_done(rsp_write_done),
`endif
    .err_unexpected_rd(err_unexpected_rd),
    .mc_in_valid(mc_in_valid), .mc_in_request_type(mc_in_request_type),
    .mc_in_request_address(mc_in_request_address), .mc_in_request_data(mc_in_request_data),
    .mc_out_busy(mc_out_busy), .mc_read_done(mc_read_done),
    .mc_data_out(mc_data_out), .mc_write_done(mc_write_done)
  );

  typedef struct { logic wr; logic [AW-1:0] addr; logic [DW-1:0] data; } xfer_t;
  typedef struct { int id; logic [DW-1:0] data; } rsp_t;

  xfer_t xfer_q[$];   // granted requests not yet taken by the controller
  rsp_t  rsp_q[$];    // read returns due next cycle
  int    rd_q[$];     // requester IDs of outstanding reads, issue order
  int    last_g;
  bit    m_err;
  int    n_vec = 0;
  int    n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    xfer_q.delete();
    rsp_q.delete();
    rd_q.delete();
    last_g = N - 1;
    m_err  = 1'b0;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0; req_type = '0; mc_out_busy = 1'b0;
    mc_read_done = 1'b0; mc_write_done = 1'b0;
    model_reset();
    #2;
    chk("rst mc_in_valid", mc_in_valid, 0);
    chk("rst mc_in_addr", mc_in_request_address, 0);
    chk("rst req_busy", req_busy, {N{1'b1}});
    chk("rst rsp_read_done", rsp_read_done, 0);
    chk("rst rsp_data", rsp_data, 0);
    chk("rst err", err_unexpected_rd, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One cycle: drive random inputs, predict the grant, advance the model at the edge.
  task automatic cycle(input int pv, input int pw, input int pb, input int pr, input bit force_rd);
    int g;
    logic [N-1:0] eb;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = ($urandom_range(0, 99) < pv);
      req_type[i]            = ($urandom_range(0, 99) < pw);
      req_addr[i*AW +: AW]   = AW'($urandom);
      req_data[i*DW +: DW]   = DW'($urandom);
    end
    mc_out_busy  = ($urandom_range(0, 99) < pb);
    mc_read_done = force_rd || (rd_q.size() > 0 && $urandom_range(0, 99) < pr);
    mc_data_out  = DW'($urandom);
    #1;
    g = -1;
    if (xfer_q.size() == 0 || !mc_out_busy) begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (last_g + k) % N;
        if (g < 0 && req_valid[i] && (req_type[i] || rd_q.size() < DEPTH)) g = i;
      end
    end
    eb = '1;
    if (g >= 0) eb[g] = 1'b0;
    chk("req_busy", req_busy, eb);
    n_vec++;
    @(posedge clk);
    if (mc_read_done) begin
      if (rd_q.size() > 0) rsp_q.push_back('{rd_q.pop_front(), mc_data_out});
      else m_err = 1'b1;
    end
    if (g >= 0) begin
      last_g = g;
      xfer_q.push_back('{req_type[g], req_addr[g*AW +: AW], req_data[g*DW +: DW]});
      if (!req_type[g]) rd_q.push_back(g);
    end
  endtask

  task automatic phase(input int n, input int pv, input int pw, input int pb, input int pr, input bit f);
    for (int c = 0; c < n; c++) cycle(pv, pw, pb, pr, f);
  endtask

  // Monitor: compares what the DUT presents against the scoreboard queues.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rst !== 1'b0) continue;
      chk("mc_in_valid", mc_in_valid, xfer_q.size() > 0);
      if (mc_in_valid && xfer_q.size() > 0) begin
        chk("mc_in_type", mc_in_request_type, xfer_q[0].wr);
        chk("mc_in_addr", mc_in_request_address, xfer_q[0].addr);
        chk("mc_in_data", mc_in_request_data, xfer_q[0].data);
        if (!mc_out_busy) void'(xfer_q.pop_front());
      end
      if (rsp_q.size() > 0) begin
        chk("rsp_read_done", rsp_read_done, 64'(1) << rsp_q[0].id);
        chk("rsp_data", rsp_data, rsp_q[0].data);
        void'(rsp_q.pop_front());
      end else begin
        chk("rsp_read_done idle", rsp_read_done, 0);
      end
      chk("err_unexpected_rd", err_unexpected_rd, m_err);
    end
  end

  initial begin
    rst = 1'b1;
    req_valid = '0; req_type = '0; req_addr = '0; req_data = '0;
    mc_out_busy = 1'b0; mc_read_done = 1'b0; mc_write_done = 1'b0; mc_data_out = '0;
    model_reset();
    reset_pulse();
    phase(40, 100, 100, 0, 0, 1'b0);   // all writes: strict 0,1,2,3 rotation
    phase(60, 60, 30, 20, 30, 1'b0);
    phase(60, 90, 5, 10, 3, 1'b0);     // pile up reads until the ID FIFO fills
    phase(30, 80, 50, 80, 20, 1'b0);   // long controller stalls
    phase(40, 0, 0, 0, 100, 1'b0);     // drain all outstanding reads
    phase(3, 0, 0, 0, 0, 1'b1);        // read returns with nothing outstanding
    phase(40, 70, 40, 30, 30, 1'b0);
    phase(20, 90, 10, 60, 5, 1'b0);
    reset_pulse();                      // mid-operation reset
    phase(40, 100, 50, 10, 30, 1'b0);
    phase(200, 60, 50, 25, 30, 1'b0);
    phase(40, 0, 0, 0, 100, 1'b0);
    @(negedge clk);
    #4;
    chk("xfer queue drained", 64'(xfer_q.size()), 0);
    chk("rd queue drained", 64'(rd_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_request_arbiter.md
# mc_request_arbiter

Round-robin arbiter that shares the memory controller's single request port among `NUM_REQ` requesters. It sits between the client logic and the controller front end, forwarding one request per accepted handshake. It records the requester ID of every read in issue order so each `read_done`/`data_out` beat returns to the requester that issued the read. Controller reads complete in issue order; the arbiter depends on this.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (≥2).
- `DATA_WIDTH`, 16: request and read-data width.
- `ADDR_WIDTH`, 30: request address width.
- `RD_FIFO_DEPTH`, 16: maximum outstanding reads (power of 2).

Ports:
- `clk`  in  1: clock; all logic on its rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `req_valid`  in  NUM_REQ: per-requester request valid.
- `req_busy`  out  NUM_REQ: per-requester busy. A request is accepted on an edge where `req_valid[i]=1` and `req_busy[i]=0`.
- `req_type`  in  NUM_REQ: 1 = write, 0 = read.
- `req_addr`  in  NUM_REQ*ADDR_WIDTH: packed addresses; slot i is at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_data`  in  NUM_REQ*DATA_WIDTH: packed write data.
- `rsp_read_done`  out  NUM_REQ: one-hot read-return strobe.
- `rsp_data`  out  DATA_WIDTH: read data, qualified by `rsp_read_done`.
- `rsp_write_done`  out  NUM_REQ: one-hot write-completion strobe. Present only under `MC_ARB_WR_ACK_EN`.
- `err_unexpected_rd`  out  1: sticky flag; set by a read return that has no outstanding read.
- `mc_in_valid`, `mc_in_request_type`, `mc_in_request_address`, `mc_in_request_data`  out: request to the controller.
- `mc_out_busy`  in  1: controller busy. A request transfers on an edge where `mc_in_valid=1` and `mc_out_busy=0`.
- `mc_read_done`, `mc_data_out`, `mc_write_done`  in: controller completions.

## Operation
- One-entry output register `oreg` drives all `mc_in_*` signals. FSM has two states:
  - EMPTY: `mc_in_valid=0`.
  - FULL: `mc_in_valid=1`.
- `oreg` is free when the FSM is EMPTY, or when it is FULL and `mc_out_busy=0` (drain and refill in the same cycle).
- Eligible requester: `req_valid[i]=1`, and, if `req_type[i]=0` (read), the read-ID FIFO is not full.
- When `oreg` is free, exactly one eligible requester is granted.
  - Round-robin order starts at `last_grant+1` modulo NUM_REQ.
  - `last_grant` updates only on a grant.
  - `req_busy[g]=0` for the granted requester; every other bit is 1.
  - No grant when nothing is eligible or `oreg` is not free; `req_busy` is then all ones.
- On a grant: `oreg` loads type, address and data of requester g; FSM moves to FULL.
- FULL with transfer and no new grant: FSM moves to EMPTY.
- Read grant: push g into the read-ID FIFO in the same edge.
- `mc_read_done=1`:
  - pop the FIFO head h;
  - next cycle: `rsp_read_done = 1<<h` and `rsp_data` = registered `mc_data_out`.
- FIFO full:
  - reads are masked from arbitration even if a pop occurs in the same cycle;
  - writes still arbitrate.
- FIFO empty with `mc_read_done=1`: no pop, no strobe, set `err_unexpected_rd`. The flag clears only on `rst`.
- Push and pop in the same cycle: count unchanged; head and tail both advance.

## Timing
- Upstream accept at edge k → `mc_in_valid=1` during cycle k+1.
- Back-to-back grants sustain one request per cycle while `mc_out_busy=0`.
- `mc_out_busy=1`: `oreg` holds all fields stable. No new grant.
- `mc_read_done` sampled at edge k → `rsp_read_done`/`rsp_data` valid during cycle k+1, for one cycle.
- Reset values (asynchronous, `rst=1`):
  - `mc_in_valid=0`, `mc_in_*` fields 0, FSM EMPTY;
  - `req_busy` all ones;
  - `rsp_read_done=0`, `rsp_data=0`, `rsp_write_done=0`;
  - `err_unexpected_rd=0`;
  - FIFO count 0;
  - `last_grant=NUM_REQ-1`, so requester 0 wins first.
- Reset asserted mid-operation discards `oreg` and all FIFO contents. Controller completions arriving afterwards for discarded requests set `err_unexpected_rd`.
- FIFO pointers are `$clog2(RD_FIFO_DEPTH)` bits and wrap naturally. Count is `$clog2(RD_FIFO_DEPTH)+1` bits.

## Configuration
- `MC_ARB_WR_ACK_EN` defined:
  - adds a second ID FIFO (depth `RD_FIFO_DEPTH`) pushed on write grants and popped on `mc_write_done`;
  - `rsp_write_done` pulses one-hot one cycle after `mc_write_done`;
  - writes are masked while this FIFO is full;
  - an unexpected `mc_write_done` also sets `err_unexpected_rd`.
- Undefined: `rsp_write_done` port absent, `mc_write_done` ignored, writes are never masked.

## Structure
- Package `mc_arb_pkg` holds:
  - `req_type_e` (READ=0, WRITE=1);
  - `req_id_t` sized `$clog2(NUM_REQ)`;
  - default width constants.
- Sub-module `mc_arb_id_fifo`: parameterized synchronous FIFO with push, pop, full, empty and head. Instantiated once, or twice under the macro.

## Test plan
- All 4 requesters hold write requests, `mc_out_busy=0` → grants in order 0,1,2,3,0,… at one per cycle; `mc_in_request_data` follows that order.
- Requester 2 issues reads to addresses 5, 6, 7; the controller returns 0x0005, 0x0006, 0x0007 → `rsp_read_done=4'b0100` three times, with data in the same order.
- 16 reads outstanding, then requester 1 issues a read and requester 3 a write → only the write is granted; the read is granted on the cycle after the first `mc_read_done`.
- `mc_out_busy=1` for 5 cycles while FULL → `mc_in_*` stable for 5 cycles, `req_busy` all ones, no duplicate transfer.
- `mc_read_done=1` with the FIFO empty → no `rsp_read_done`, and `err_unexpected_rd=1` until `rst`.
- `rst` pulsed while FULL with 3 reads outstanding → next cycle `mc_in_valid=0`, FIFO empty, and requester 0 is granted first.
